// File: rtl/spi_master_multimode_if.sv
// ---------------------------------------------------------------------------
// spi_master_multimode_if
//   Bundles the controller handshake and the SPI pins of spi_master_multimode.
//   Optional macro: SPI_MISO_EN adds the miso input and the rx_data output.
//
//   Signals:
//     din      [DATA_W] transmit word, sampled when start is accepted
//     start             transfer request (level-sampled)
//     miso              serial data from slave     (SPI_MISO_EN only)
//     busy              transfer (including the gap) in progress
//     done              one-clk pulse at transfer end
//     rx_data  [DATA_W] received word              (SPI_MISO_EN only)
//     cs_n              active-low chip select
//     sclk              serial clock
//     mosi              serial data to slave
//
//   Modports: master = the SPI block, slave = the controller / environment.
// ---------------------------------------------------------------------------
interface spi_master_multimode_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] din;
    logic              start;
    logic              busy;
    logic              done;
    logic              cs_n;
    logic              sclk;
    logic              mosi;
`ifdef SPI_MISO_EN
    logic              miso;
    logic [DATA_W-1:0] rx_data;

    modport master (
        input  din, start, miso,
        output busy, done, rx_data, cs_n, sclk, mosi
    );
    modport slave (
        output din, start, miso,
        input  busy, done, rx_data, cs_n, sclk, mosi
    );
`else
    modport master (
        input  din, start,
        output busy, done, cs_n, sclk, mosi
    );
    modport slave (
        output din, start,
        input  busy, done, cs_n, sclk, mosi
    );
`endif
endinterface

// File: rtl/spi_master_multimode.sv
// ---------------------------------------------------------------------------
// spi_master_multimode
//   SPI master: serialises a DATA_W-bit word MSB-first on mosi, with a
//   CLK_DIV-clk SCLK half-period and any CPOL/CPHA mode. A transfer runs
//   IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, each non-idle phase being
//   counted in units of CLK_DIV clks.
//   Optional macro: SPI_MISO_EN builds the receive shift register and exposes
//   bus.miso / bus.rx_data.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    spi_master_multimode_if.master (handshake + SPI pins)
// ---------------------------------------------------------------------------
module spi_master_multimode #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 10,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_master_multimode_if.master        bus
);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [EDGE_W-1:0]   r_edge;
    logic [DATA_W-1:0]   r_tx;
    logic                r_cs_n;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_busy;
    logic                r_done;
`ifdef SPI_MISO_EN
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rx_data;
`endif

    logic                w_tick;
    logic [EDGE_W-1:0]   w_edge_next;
    logic                w_leading;

    // w_tick marks the last clk of the current CLK_DIV-long slot.
    assign w_tick      = (r_div == DIV_LAST);
    assign w_edge_next = r_edge + 1'b1;
    // Edges are numbered from 1; odd numbers are leading edges.
    assign w_leading   = w_edge_next[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_edge  <= '0;
            r_tx    <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= CPOL;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SPI_MISO_EN
            r_rx      <= '0;
            r_rx_data <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_tx    <= bus.din;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        // CPHA=0 slaves sample on the first edge, so the MSB
                        // must already be on the wire during SETUP.
                        r_mosi  <= CPHA ? 1'b0 : bus.din[DATA_W-1];
                        r_div   <= '0;
                        r_edge  <= '0;
`ifdef SPI_MISO_EN
                        r_rx    <= '0;
`endif
                        r_state <= S_SETUP;
                    end
                end

                // The end of SETUP produces edge 1; each later slot of SHIFT
                // produces the next edge, and the slot after edge 2*DATA_W
                // (sclk already back at CPOL) finishes SHIFT.
                S_SETUP, S_SHIFT: begin
                    if (w_tick) begin
                        if (r_edge == EDGE_LAST) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_SHIFT;
                            r_sclk  <= ~r_sclk;
                            r_edge  <= w_edge_next;
                            if (w_leading) begin
                                if (CPHA) begin
                                    r_mosi <= r_tx[DATA_W-1];
                                    r_tx   <= r_tx << 1;
                                end
`ifdef SPI_MISO_EN
                                if (!CPHA) begin
                                    r_rx <= {r_rx[DATA_W-2:0], bus.miso};
                                end
`endif
                            end else begin
                                // The final trailing edge leaves the last bit
                                // on mosi through HOLD.
                                if (!CPHA && (w_edge_next != EDGE_LAST)) begin
                                    r_mosi <= r_tx[DATA_W-2];
                                    r_tx   <= r_tx << 1;
                                end
`ifdef SPI_MISO_EN
                                if (CPHA) begin
                                    r_rx <= {r_rx[DATA_W-2:0], bus.miso};
                                end
`endif
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (w_tick) begin
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef SPI_MISO_EN
                        r_rx_data <= r_rx;
`endif
                        r_state <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cs_n = r_cs_n;
    assign bus.sclk = r_sclk;
    assign bus.mosi = r_mosi;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
`ifdef SPI_MISO_EN
    assign bus.rx_data = r_rx_data;
`endif

endmodule

// File: tb/tb_spi_master_multimode.sv
// ---------------------------------------------------------------------------
// tb_spi_master_multimode
//   Directed bench for spi_master_multimode. Three instances:
//     u0: defaults (DATA_W=12, CLK_DIV=10, mode 0)
//     u1: DATA_W=16, CLK_DIV=2, CPOL=1, CPHA=1
//     u2: DATA_W=2,  CLK_DIV=1, mode 0
//   With SPI_MISO_EN defined, each miso is looped back from its mosi.
//   A slave-side observer records the bits seen on mosi at the sampling
//   edge of the mode, cs_n low/high interval lengths and done pulses.
// ---------------------------------------------------------------------------
module tb_spi_master_multimode;

    logic clk;
    logic rst_n;

    spi_master_multimode_if #(.DATA_W(12)) b0 ();
    spi_master_multimode_if #(.DATA_W(16)) b1 ();
    spi_master_multimode_if #(.DATA_W(2))  b2 ();

`ifdef SPI_MISO_EN
    assign b0.miso = b0.mosi;
    assign b1.miso = b1.mosi;
    assign b2.miso = b2.mosi;
`endif

    spi_master_multimode #(.DATA_W(12), .CLK_DIV(10), .CPOL(1'b0), .CPHA(1'b0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    spi_master_multimode #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    spi_master_multimode #(.DATA_W(2), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Observer state
    logic        o_prev_sclk;
    logic        o_prev_cs;
    logic [31:0] o_bits;
    int          o_bit_cnt;
    int          o_lo_len [0:7];
    int          o_hi_len [0:7];
    int          o_lo_cnt;
    int          o_hi_cnt;
    int          o_cur_low;
    int          o_cur_high;
    logic        o_seen_low;
    int          o_done_cnt;
    int          o_rise_done;
    int          o_busy_len;

    task automatic obs_clear(input logic cpol);
        o_prev_sclk = cpol;
        o_prev_cs   = 1'b1;
        o_bits      = '0;
        o_bit_cnt   = 0;
        o_lo_cnt    = 0;
        o_hi_cnt    = 0;
        o_cur_low   = 0;
        o_cur_high  = 0;
        o_seen_low  = 1'b0;
        o_done_cnt  = 0;
        o_rise_done = 0;
        o_busy_len  = 0;
        for (int i = 0; i < 8; i++) begin
            o_lo_len[i] = 0;
            o_hi_len[i] = 0;
        end
    endtask

    // Called once per clk, at the falling edge, with the current outputs.
    task automatic obs_step(input logic sclk, input logic cs_n, input logic mosi,
                            input logic done, input logic busy,
                            input logic cpol, input logic cpha);
        logic samp;
        if (cpha == 1'b0)
            samp = (o_prev_sclk == cpol) && (sclk != cpol);
        else
            samp = (o_prev_sclk != cpol) && (sclk == cpol);
        if (samp) begin
            o_bits    = {o_bits[30:0], mosi};
            o_bit_cnt = o_bit_cnt + 1;
        end
        if (!cs_n) begin
            if (o_prev_cs && o_seen_low && (o_hi_cnt < 8)) begin
                o_hi_len[o_hi_cnt] = o_cur_high;
                o_hi_cnt = o_hi_cnt + 1;
            end
            o_cur_low = o_cur_low + 1;
        end else begin
            if (!o_prev_cs) begin
                if (o_lo_cnt < 8) o_lo_len[o_lo_cnt] = o_cur_low;
                o_lo_cnt   = o_lo_cnt + 1;
                o_cur_low  = 0;
                o_seen_low = 1'b1;
                o_cur_high = 0;
                if (done) o_rise_done = o_rise_done + 1;
            end
            o_cur_high = o_cur_high + 1;
        end
        if (done) o_done_cnt = o_done_cnt + 1;
        if (busy) o_busy_len = o_busy_len + 1;
        o_prev_sclk = sclk;
        o_prev_cs   = cs_n;
    endtask

    task automatic test_reset();
        n_vec++; if (b0.cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b expected 1", b0.cs_n); end
        n_vec++; if (b0.sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk0: got %b expected 0", b0.sclk); end
        n_vec++; if (b0.mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b expected 0", b0.mosi); end
        n_vec++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", b0.busy); end
        n_vec++; if (b0.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", b0.done); end
        n_vec++; if (b1.sclk !== 1'b1) begin n_err++; $display("FAIL reset_sclk_cpol1: got %b expected 1", b1.sclk); end
`ifdef SPI_MISO_EN
        n_vec++; if (b0.rx_data !== 12'h000) begin n_err++; $display("FAIL reset_rx_data: got %h expected 000", b0.rx_data); end
`endif
        $display("test_reset: cs_n=%b sclk=%b/%b busy=%b", b0.cs_n, b0.sclk, b1.sclk, b0.busy);
    endtask

    task automatic test_mode0_basic();
        obs_clear(1'b0);
        b0.din   = 12'hA5C;
        b0.start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            b0.start = 1'b0;
            obs_step(b0.sclk, b0.cs_n, b0.mosi, b0.done, b0.busy, 1'b0, 1'b0);
        end
        n_vec++; if (o_bits[11:0] !== 12'hA5C) begin n_err++; $display("FAIL mode0_word: got %h expected a5c", o_bits[11:0]); end
        n_vec++; if (o_bit_cnt !== 12) begin n_err++; $display("FAIL mode0_edges: got %0d expected 12", o_bit_cnt); end
        n_vec++; if (o_lo_len[0] !== 260) begin n_err++; $display("FAIL mode0_cs_low: got %0d expected 260", o_lo_len[0]); end
        n_vec++; if (o_done_cnt !== 1) begin n_err++; $display("FAIL mode0_done_cnt: got %0d expected 1", o_done_cnt); end
        n_vec++; if (o_rise_done !== 1) begin n_err++; $display("FAIL mode0_done_at_cs_rise: got %0d expected 1", o_rise_done); end
        n_vec++; if (o_busy_len !== 270) begin n_err++; $display("FAIL mode0_busy_len: got %0d expected 270", o_busy_len); end
        n_vec++; if (b0.sclk !== 1'b0) begin n_err++; $display("FAIL mode0_sclk_idle: got %b expected 0", b0.sclk); end
`ifdef SPI_MISO_EN
        n_vec++; if (b0.rx_data !== 12'hA5C) begin n_err++; $display("FAIL mode0_rx_data: got %h expected a5c", b0.rx_data); end
`endif
        $display("test_mode0_basic: word=%h edges=%0d cs_low=%0d dones=%0d busy=%0d",
                 o_bits[11:0], o_bit_cnt, o_lo_len[0], o_done_cnt, o_busy_len);
    endtask

    task automatic test_mode3_loopback();
        n_vec++; if (b1.sclk !== 1'b1) begin n_err++; $display("FAIL mode3_sclk_idle_pre: got %b expected 1", b1.sclk); end
        obs_clear(1'b1);
        b1.din   = 16'hBEEF;
        b1.start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            b1.start = 1'b0;
            obs_step(b1.sclk, b1.cs_n, b1.mosi, b1.done, b1.busy, 1'b1, 1'b1);
        end
        n_vec++; if (o_bits[15:0] !== 16'hBEEF) begin n_err++; $display("FAIL mode3_word: got %h expected beef", o_bits[15:0]); end
        n_vec++; if (o_bit_cnt !== 16) begin n_err++; $display("FAIL mode3_edges: got %0d expected 16", o_bit_cnt); end
        n_vec++; if (o_lo_len[0] !== 68) begin n_err++; $display("FAIL mode3_cs_low: got %0d expected 68", o_lo_len[0]); end
        n_vec++; if (o_done_cnt !== 1) begin n_err++; $display("FAIL mode3_done_cnt: got %0d expected 1", o_done_cnt); end
        n_vec++; if (b1.sclk !== 1'b1) begin n_err++; $display("FAIL mode3_sclk_idle_post: got %b expected 1", b1.sclk); end
`ifdef SPI_MISO_EN
        n_vec++; if (b1.rx_data !== 16'hBEEF) begin n_err++; $display("FAIL mode3_rx_data: got %h expected beef", b1.rx_data); end
`endif
        $display("test_mode3_loopback: word=%h edges=%0d cs_low=%0d dones=%0d",
                 o_bits[15:0], o_bit_cnt, o_lo_len[0], o_done_cnt);
    endtask

    task automatic test_start_ignored();
        obs_clear(1'b0);
        b0.din   = 12'hA5C;
        b0.start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 50) begin
                b0.din   = 12'h123;
                b0.start = 1'b1;
            end else begin
                b0.start = 1'b0;
            end
            obs_step(b0.sclk, b0.cs_n, b0.mosi, b0.done, b0.busy, 1'b0, 1'b0);
        end
        n_vec++; if (o_bits[11:0] !== 12'hA5C) begin n_err++; $display("FAIL ignore_word: got %h expected a5c", o_bits[11:0]); end
        n_vec++; if (o_done_cnt !== 1) begin n_err++; $display("FAIL ignore_done_cnt: got %0d expected 1", o_done_cnt); end
        n_vec++; if (o_lo_cnt !== 1) begin n_err++; $display("FAIL ignore_cs_frames: got %0d expected 1", o_lo_cnt); end
        $display("test_start_ignored: word=%h dones=%0d frames=%0d", o_bits[11:0], o_done_cnt, o_lo_cnt);
    endtask

    task automatic test_back_to_back();
        obs_clear(1'b0);
        b0.din   = 12'hA5C;
        b0.start = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            obs_step(b0.sclk, b0.cs_n, b0.mosi, b0.done, b0.busy, 1'b0, 1'b0);
            if (o_done_cnt >= 3) b0.start = 1'b0;
        end
        b0.start = 1'b0;
        n_vec++; if (o_done_cnt !== 3) begin n_err++; $display("FAIL b2b_done_cnt: got %0d expected 3", o_done_cnt); end
        n_vec++; if (o_lo_cnt !== 3) begin n_err++; $display("FAIL b2b_frames: got %0d expected 3", o_lo_cnt); end
        n_vec++; if (o_hi_cnt !== 2) begin n_err++; $display("FAIL b2b_gaps: got %0d expected 2", o_hi_cnt); end
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (o_hi_len[i] !== 11) begin n_err++; $display("FAIL b2b_gap_len[%0d]: got %0d expected 11", i, o_hi_len[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (o_lo_len[i] !== 260) begin n_err++; $display("FAIL b2b_cs_low[%0d]: got %0d expected 260", i, o_lo_len[i]); end
        end
        $display("test_back_to_back: dones=%0d gaps=%0d,%0d lows=%0d,%0d,%0d",
                 o_done_cnt, o_hi_len[0], o_hi_len[1], o_lo_len[0], o_lo_len[1], o_lo_len[2]);
    endtask

    task automatic test_reset_mid();
        obs_clear(1'b0);
        b0.din   = 12'hA5C;
        b0.start = 1'b1;
        // Accept at the next rising edge; SHIFT begins 10 clks later.
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            b0.start = 1'b0;
        end
        n_vec++; if (b0.cs_n !== 1'b0) begin n_err++; $display("FAIL rstmid_pre_cs_n: got %b expected 0", b0.cs_n); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (b0.cs_n !== 1'b1) begin n_err++; $display("FAIL rstmid_cs_n: got %b expected 1", b0.cs_n); end
        n_vec++; if (b0.sclk !== 1'b0) begin n_err++; $display("FAIL rstmid_sclk: got %b expected 0", b0.sclk); end
        n_vec++; if (b0.mosi !== 1'b0) begin n_err++; $display("FAIL rstmid_mosi: got %b expected 0", b0.mosi); end
        n_vec++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", b0.busy); end
`ifdef SPI_MISO_EN
        n_vec++; if (b0.rx_data !== 12'h000) begin n_err++; $display("FAIL rstmid_rx_data: got %h expected 000", b0.rx_data); end
`endif
        obs_clear(1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            obs_step(b0.sclk, b0.cs_n, b0.mosi, b0.done, b0.busy, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            obs_step(b0.sclk, b0.cs_n, b0.mosi, b0.done, b0.busy, 1'b0, 1'b0);
        end
        n_vec++; if (o_done_cnt !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d expected 0", o_done_cnt); end
        // Fresh transfer after release.
        obs_clear(1'b0);
        b0.din   = 12'h3C6;
        b0.start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            b0.start = 1'b0;
            obs_step(b0.sclk, b0.cs_n, b0.mosi, b0.done, b0.busy, 1'b0, 1'b0);
        end
        n_vec++; if (o_bits[11:0] !== 12'h3C6) begin n_err++; $display("FAIL rstmid_fresh_word: got %h expected 3c6", o_bits[11:0]); end
        n_vec++; if (o_done_cnt !== 1) begin n_err++; $display("FAIL rstmid_fresh_done: got %0d expected 1", o_done_cnt); end
        n_vec++; if (o_lo_len[0] !== 260) begin n_err++; $display("FAIL rstmid_fresh_cs_low: got %0d expected 260", o_lo_len[0]); end
        $display("test_reset_mid: fresh word=%h dones=%0d cs_low=%0d", o_bits[11:0], o_done_cnt, o_lo_len[0]);
    endtask

    task automatic test_min_config();
        obs_clear(1'b0);
        b2.din   = 2'b10;
        b2.start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            b2.start = 1'b0;
            obs_step(b2.sclk, b2.cs_n, b2.mosi, b2.done, b2.busy, 1'b0, 1'b0);
        end
        n_vec++; if (o_bits[1:0] !== 2'b10) begin n_err++; $display("FAIL min_word: got %b expected 10", o_bits[1:0]); end
        n_vec++; if (o_bit_cnt !== 2) begin n_err++; $display("FAIL min_edges: got %0d expected 2", o_bit_cnt); end
        n_vec++; if (o_lo_len[0] !== 6) begin n_err++; $display("FAIL min_cs_low: got %0d expected 6", o_lo_len[0]); end
        n_vec++; if (o_rise_done !== 1) begin n_err++; $display("FAIL min_done_at_cs_rise: got %0d expected 1", o_rise_done); end
        n_vec++; if (o_done_cnt !== 1) begin n_err++; $display("FAIL min_done_cnt: got %0d expected 1", o_done_cnt); end
        n_vec++; if (o_busy_len !== 7) begin n_err++; $display("FAIL min_busy_len: got %0d expected 7", o_busy_len); end
`ifdef SPI_MISO_EN
        n_vec++; if (b2.rx_data !== 2'b10) begin n_err++; $display("FAIL min_rx_data: got %b expected 10", b2.rx_data); end
`endif
        $display("test_min_config: word=%b cs_low=%0d dones=%0d busy=%0d",
                 o_bits[1:0], o_lo_len[0], o_done_cnt, o_busy_len);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        b0.din   = '0;
        b0.start = 1'b0;
        b1.din   = '0;
        b1.start = 1'b0;
        b2.din   = '0;
        b2.start = 1'b0;
        obs_clear(1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_mode0_basic();
        test_mode3_loopback();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_min_config();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_multimode.md
# spi_master_multimode

Parametrised SPI master and successor to the team's fixed 12-bit transmit-only SPI block. It serialises a DATA_W-bit word MSB-first on MOSI, with configurable SCLK rate and all four CPOL/CPHA modes. An optional full-duplex MISO capture path is included. It sits between a register-level controller (start/busy/done handshake) and an external SPI slave such as a DAC or ADC.

## Interface
Parameters:
- DATA_W, 12, bits per transfer; legal range ≥2.
- CLK_DIV, 10, SCLK half-period in clk cycles; legal range ≥1.
- CPOL, 0, SCLK idle level.
- CPHA, 0, clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  transmit word; sampled only when start is accepted.
- start  in  1  transfer request; level-sampled each clk.
- miso  in  1  serial data from slave; present only with SPI_MISO_EN.
- busy  out  1  high while a transfer (including the gap) is in progress.
- done  out  1  one-clk pulse at transfer end.
- rx_data  out  DATA_W  received word; present only with SPI_MISO_EN.
- cs_n  out  1  active-low chip select.
- sclk  out  1  serial clock.
- mosi  out  1  serial data to slave.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- Reset values (asynchronous, immediate): cs_n=1, sclk=CPOL, mosi=0, done=0, busy=0, rx_data=0, state IDLE, counters 0.
- IDLE: if start=1, latch din into the shift register, drive cs_n=0, set busy=1, enter SETUP. start during any other state is ignored; no queuing.
- SETUP: lasts CLK_DIV clks.
  - CPHA=0: mosi = din[DATA_W-1] from SETUP entry.
- SHIFT: 2*DATA_W SCLK edges, one every CLK_DIV clks. The first edge is the leading edge (away from CPOL).
  - CPHA=0: miso sampled on leading edges; mosi advances to the next bit on trailing edges, except the last one.
  - CPHA=1: mosi updates on each leading edge, with bit DATA_W-1 on the first; miso sampled on trailing edges.
  - The receive register shifts in MSB-first.
- HOLD: CLK_DIV clks with sclk=CPOL, cs_n=0, mosi holding the last bit.
- Leaving HOLD: cs_n=1, mosi=0, done=1 for one clk, rx_data updated from the receive register, enter GAP.
- GAP: CLK_DIV clks with cs_n=1 and busy=1. Then busy=0 and return to IDLE.
- rx_data holds its value until the next done.
- A held start launches back-to-back transfers separated by exactly CLK_DIV+1 clks of cs_n high (the GAP plus the IDLE accept cycle).
- Counter widths: $clog2(CLK_DIV+1) for the divider and $clog2(2*DATA_W+1) for the edge counter. No wrap occurs within a legal transfer.
- Reset asserted mid-transfer abandons the transfer: no done pulse, rx_data cleared.

## Timing
- Start accepted at clk edge k: cs_n falls and busy rises after edge k.
- cs_n stays low for exactly (2*DATA_W+2)*CLK_DIV clks. Defaults: 260 clks.
- done pulses in the clk after cs_n rises, concurrent with that rise. busy falls CLK_DIV clks later.
- Start-to-done latency: (2*DATA_W+2)*CLK_DIV+1 clks.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SPI_MISO_EN defined:
  - miso port and rx_data port exist.
  - Receive shift register is built.
- SPI_MISO_EN undefined:
  - Both ports and the receive logic are removed.
  - Transmit timing is identical.

## Test plan
- Defaults (mode 0), din=12'hA5C, single start pulse:
  - mosi on successive leading edges reads 1,0,1,0,0,1,0,1,1,1,0,0.
  - cs_n low for 260 clks.
  - Exactly one done pulse.
- CPOL=1, CPHA=1, DATA_W=16, CLK_DIV=2, SPI_MISO_EN, miso looped to mosi, din=16'hBEEF:
  - rx_data==16'hBEEF at done.
  - sclk idles high.
- start re-pulsed during SHIFT with din=12'h123:
  - Ignored; transmitted word stays 12'hA5C.
  - One done pulse only.
- start held high for three transfers:
  - Three done pulses.
  - Each cs_n-high interval is exactly CLK_DIV+1 clks.
- rst_n asserted at the 50th SHIFT clk:
  - cs_n=1, sclk=CPOL, mosi=0, busy=0 immediately.
  - No done pulse.
  - A fresh start after release completes normally.
- CLK_DIV=1, DATA_W=2, din=2'b10:
  - cs_n low for 6 clks.
  - mosi 1 then 0.
  - done pulses in the clk after cs_n rises.
